// File: rtl/fpu_conv_scheduler_if.sv
// Line-memory port and FPU control bundle shared by the convolution scheduler and its neighbours.
// Handshake: the requester holds req high with a stable address until ack is seen; a one-cycle
// ack completes the transfer, may arrive in the first req cycle, and is ignored while req is low.
interface fpu_conv_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic [1:0]        fpu_load_row;
  logic              fpu_go;
  logic              fpu_last_chunk;
  logic              fpu_done;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              mem_wr_ack;

  modport master (
    output mem_rd_req, mem_rd_addr, fpu_load_row, fpu_go, fpu_last_chunk,
    output mem_wr_req, mem_wr_addr,
    input  mem_rd_ack, fpu_done, mem_wr_ack
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, fpu_load_row, fpu_go, fpu_last_chunk,
    input  mem_wr_req, mem_wr_addr,
    output mem_rd_ack, fpu_done, mem_wr_ack
  );
endinterface

// File: rtl/fpu_conv_scheduler.sv
// Walks output rows and line-sized column chunks of a 3x3 convolution: three row reads, FPU run,
// one result write per chunk. Define FPU_SCHED_PERF_EN to add stall_cycles/chunk_count counters.
module fpu_conv_scheduler #(
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] result_address,
  fpu_conv_scheduler_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              dim_err,
  output logic [2:0]        fsm_state
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       chunk_count
`endif
);
  localparam int LB_SHIFT = $clog2(LINE_BYTES);
  localparam int PW       = 2 * DIM_W;
  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD0     = 3'd1,
    RD1     = 3'd2,
    RD2     = 3'd3,
    COMPUTE = 3'd4,
    WRITE   = 3'd5,
    ADVANCE = 3'd6,
    FINISH  = 3'd7
  } state_t;

  state_t state, state_next;

  logic [DIM_W-1:0]  width_q, height_q, row_q, col_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic              busy_q, dim_err_q, go_issued_q;

  logic              accept, dims_bad, last_col, last_row;
  logic [DIM_W-1:0]  last_col_idx, rd_row;
  logic [1:0]        rd_k;
  logic [PW-1:0]     rd_prod, wr_prod;
  logic [ADDR_W-1:0] col_off, rd_addr, wr_addr;

  assign accept   = (state == IDLE) && start;
  assign dims_bad = (image_width < MIN_DIM) || (image_height < MIN_DIM);

  // Index of the final (possibly partial) chunk: ceil(W/LINE_BYTES)-1 without an overflowing add.
  assign last_col_idx = (width_q - DIM_W'(1)) >> LB_SHIFT;
  assign last_col     = (col_q == last_col_idx);
  assign last_row     = (row_q == (height_q - MIN_DIM));

  always_comb begin
    case (state)
      RD1:     rd_k = 2'd1;
      RD2:     rd_k = 2'd2;
      default: rd_k = 2'd0;
    endcase
  end

  assign rd_row  = row_q + DIM_W'(rd_k);
  assign rd_prod = PW'(rd_row) * PW'(width_q);
  assign wr_prod = PW'(row_q) * PW'(width_q);
  assign col_off = ADDR_W'(col_q) << LB_SHIFT;
  assign rd_addr = src_q + ADDR_W'(rd_prod) + col_off;
  assign wr_addr = dst_q + ADDR_W'(wr_prod) + col_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.mem_rd_req     = 1'b0;
    bus.mem_rd_addr    = '0;
    bus.fpu_load_row   = 2'd0;
    bus.fpu_go         = 1'b0;
    bus.fpu_last_chunk = 1'b0;
    bus.mem_wr_req     = 1'b0;
    bus.mem_wr_addr    = '0;
    done               = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = dims_bad ? FINISH : RD0;
      end
      RD0, RD1, RD2: begin
        bus.mem_rd_req     = 1'b1;
        bus.mem_rd_addr    = rd_addr;
        bus.fpu_load_row   = rd_k;
        bus.fpu_last_chunk = last_col;
        if (bus.mem_rd_ack) begin
          case (state)
            RD0:     state_next = RD1;
            RD1:     state_next = RD2;
            default: state_next = COMPUTE;
          endcase
        end
      end
      COMPUTE: begin
        bus.fpu_go         = !go_issued_q;
        bus.fpu_last_chunk = last_col;
        if (bus.fpu_done) state_next = WRITE;
      end
      WRITE: begin
        bus.mem_wr_req     = 1'b1;
        bus.mem_wr_addr    = wr_addr;
        bus.fpu_last_chunk = last_col;
        if (bus.mem_wr_ack) state_next = ADVANCE;
      end
      ADVANCE: begin
        state_next = (last_row && last_col) ? FINISH : RD0;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q     <= '0;
      height_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      dim_err_q   <= 1'b0;
      go_issued_q <= 1'b0;
    end else begin
      // Marks that the single fpu_go of this COMPUTE visit has already been issued.
      go_issued_q <= (state == COMPUTE);
      if (accept) begin
        width_q   <= image_width;
        height_q  <= image_height;
        src_q     <= start_address;
        dst_q     <= result_address;
        row_q     <= '0;
        col_q     <= '0;
        busy_q    <= 1'b1;
        dim_err_q <= dims_bad;
      end
      if (state == ADVANCE) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
      if (state == FINISH) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign dim_err   = dim_err_q;
  assign fsm_state = state;

`ifdef FPU_SCHED_PERF_EN
  logic stall;
  assign stall = (bus.mem_rd_req && !bus.mem_rd_ack) || (bus.mem_wr_req && !bus.mem_wr_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      chunk_count  <= '0;
    end else if (accept) begin
      stall_cycles <= '0;
      chunk_count  <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if ((state == ADVANCE) && (chunk_count != '1)) chunk_count <= chunk_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_conv_scheduler.sv
// Bench for fpu_conv_scheduler: vector table, hand-written corner sequences, random jobs,
// all scored against an event queue built from the row/chunk address rules.
module tb_fpu_conv_scheduler;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LB = 64;
  localparam int EW = 40;
  localparam logic [3:0] EV_RD = 4'd1, EV_GO = 4'd2, EV_WR = 4'd3, EV_DONE = 4'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] image_width = '0, image_height = '0;
  logic [AW-1:0] start_address = '0, result_address = '0;
  logic busy, done, dim_err;
  logic [2:0] fsm_state;
`ifdef FPU_SCHED_PERF_EN
  logic [31:0] stall_cycles, chunk_count;
`endif

  always #5 clk = ~clk;

  fpu_conv_scheduler_if #(.ADDR_W(AW)) bus ();

  fpu_conv_scheduler #(.LINE_BYTES(LB), .ADDR_W(AW), .DIM_W(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .image_width(image_width),
    .image_height(image_height),
    .start_address(start_address),
    .result_address(result_address),
    .bus(bus),
    .busy(busy),
    .done(done),
    .dim_err(dim_err),
    .fsm_state(fsm_state)
`ifdef FPU_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .chunk_count(chunk_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] obs_rd[$];
  logic [31:0] obs_wr[$];
  int go_count = 0;
  int rd_lat_cfg = 0, wr_lat_cfg = 0, fpu_lat_cfg = 1;
  bit noise = 1'b0;

  function automatic logic [EW-1:0] mk_ev(input logic [3:0] typ, input logic last,
                                          input logic [1:0] row, input logic [31:0] addr);
    return {typ, last, row, 1'b0, addr};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic score(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%h required=nothing", got);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        bad++;
        $display("FAIL event got=%h required=%h", got, e);
      end
    end
  endtask

  // Reference: every chunk of every output row, in row-major order, as a list of bus events.
  function automatic int build_expected(input int w, input int h, input logic [31:0] sa,
                                        input logic [31:0] ra);
    int n_col, n;
    logic [63:0] a;
    logic lst;
    exp_q.delete();
    n = 0;
    if (w >= 3 && h >= 3) begin
      n_col = (w + LB - 1) / LB;
      for (int r = 0; r <= h - 3; r++) begin
        for (int c = 0; c < n_col; c++) begin
          lst = (c == n_col - 1);
          for (int k = 0; k < 3; k++) begin
            a = 64'(sa) + 64'((r + k) * w) + 64'(c * LB);
            exp_q.push_back(mk_ev(EV_RD, lst, k[1:0], a[31:0]));
          end
          exp_q.push_back(mk_ev(EV_GO, lst, 2'd0, 32'd0));
          a = 64'(ra) + 64'(r * w) + 64'(c * LB);
          exp_q.push_back(mk_ev(EV_WR, lst, 2'd0, a[31:0]));
          n++;
        end
      end
    end
    exp_q.push_back(mk_ev(EV_DONE, 1'b0, 2'd0, 32'd0));
    return n;
  endfunction

  function automatic int pick(input int cfg, input int lo);
    return (cfg < 0) ? int'($urandom_range(4, lo)) : cfg;
  endfunction

  // ---------------- memory / FPU responder and monitor ----------------
  initial begin
    int rd_wait, wr_wait, fpu_cnt, rd_lat, wr_lat;
    logic [31:0] rd_hold, wr_hold;
    rd_wait = 0; wr_wait = 0; fpu_cnt = 0; rd_lat = 0; wr_lat = 0;
    rd_hold = '0; wr_hold = '0;
    bus.mem_rd_ack = 1'b0;
    bus.mem_wr_ack = 1'b0;
    bus.fpu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.mem_rd_ack = 1'b0;
        bus.mem_wr_ack = 1'b0;
        bus.fpu_done = 1'b0;
        rd_wait = 0; wr_wait = 0; fpu_cnt = 0;
      end else begin
        if (rd_wait != 0) check("rd_req_held", bus.mem_rd_req, 1'b1);
        if (bus.mem_rd_req) begin
          if (rd_wait == 0) rd_lat = pick(rd_lat_cfg, 0);
          else check("rd_addr_stable", bus.mem_rd_addr, rd_hold);
          rd_hold = bus.mem_rd_addr;
          if (rd_wait >= rd_lat) begin
            bus.mem_rd_ack = 1'b1;
            score(mk_ev(EV_RD, bus.fpu_last_chunk, bus.fpu_load_row, bus.mem_rd_addr));
            obs_rd.push_back(bus.mem_rd_addr);
            rd_wait = 0;
          end else begin
            bus.mem_rd_ack = 1'b0;
            rd_wait++;
          end
        end else begin
          rd_wait = 0;
          bus.mem_rd_ack = noise && ($urandom_range(3, 0) == 0);
        end

        if (wr_wait != 0) check("wr_req_held", bus.mem_wr_req, 1'b1);
        if (bus.mem_wr_req) begin
          if (wr_wait == 0) wr_lat = pick(wr_lat_cfg, 0);
          else check("wr_addr_stable", bus.mem_wr_addr, wr_hold);
          wr_hold = bus.mem_wr_addr;
          if (wr_wait >= wr_lat) begin
            bus.mem_wr_ack = 1'b1;
            score(mk_ev(EV_WR, bus.fpu_last_chunk, 2'd0, bus.mem_wr_addr));
            obs_wr.push_back(bus.mem_wr_addr);
            wr_wait = 0;
          end else begin
            bus.mem_wr_ack = 1'b0;
            wr_wait++;
          end
        end else begin
          wr_wait = 0;
          bus.mem_wr_ack = noise && ($urandom_range(3, 0) == 0);
        end

        bus.fpu_done = 1'b0;
        if (fpu_cnt > 0) begin
          fpu_cnt--;
          if (fpu_cnt == 0) bus.fpu_done = 1'b1;
        end
        if (bus.fpu_go) begin
          score(mk_ev(EV_GO, bus.fpu_last_chunk, 2'd0, 32'd0));
          go_count++;
          fpu_cnt = pick(fpu_lat_cfg, 1);
        end else if (fpu_cnt == 0 && !bus.fpu_done) begin
          bus.fpu_done = noise && ($urandom_range(3, 0) == 0);
        end

        if (done) score(mk_ev(EV_DONE, 1'b0, 2'd0, 32'd0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_job(input string name, input int w, input int h, input logic [31:0] sa,
                         input logic [31:0] ra, input int budget, output int lat, output int n_chunks);
    int n;
    bit seen;
    n_chunks = build_expected(w, h, sa, ra);
    obs_rd.delete();
    obs_wr.delete();
    go_count = 0;
    @(posedge clk); #1;
    image_width = DW'(w);
    image_height = DW'(h);
    start_address = sa;
    result_address = ra;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    image_width = DW'($urandom);
    image_height = DW'($urandom);
    start_address = $urandom;
    result_address = $urandom;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, "_busy_on"}, busy, 1'b1);
      if (done) seen = 1'b1;
    end
    lat = n;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=no done required=done within %0d cycles", name, budget);
      pulse_reset();
    end else begin
      @(negedge clk);
      check({name, "_busy_off"}, busy, 1'b0);
      check({name, "_done_pulse"}, done, 1'b0);
      check({name, "_events_left"}, exp_q.size(), 0);
`ifdef FPU_SCHED_PERF_EN
      check({name, "_chunk_count"}, chunk_count, n_chunks);
`endif
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    int w; int h;
    logic [31:0] sa; logic [31:0] ra;
    int rdl; int wrl; int fpl;
    bit err; int chunks; int done_lat;
    logic [31:0] rd0; logic [31:0] rd1; logic [31:0] rd2;
    logic [31:0] wr0; logic [31:0] wr_last;
  } vec_t;

  localparam int NV = 8;
  vec_t vec[NV];

  initial begin
    int lat, nch, w, h, budget;
    string nm;
    vec[0] = '{64,  3, 32'h1000,     32'h2000, 0, 0, 1, 1'b0, 1,  8,  32'h1000,     32'h1040, 32'h1080, 32'h2000, 32'h2000};
    vec[1] = '{100, 4, 32'h0,        32'h8000, 0, 0, 1, 1'b0, 4,  -1, 32'h0,        32'h64,   32'hC8,   32'h8000, 32'h80A4};
    vec[2] = '{2,  10, 32'h0,        32'h0,    0, 0, 1, 1'b1, 0,  1,  32'h0,        32'h0,    32'h0,    32'h0,    32'h0};
    vec[3] = '{200, 5, 32'h100,      32'h4000, 2, 3, 4, 1'b0, 12, -1, 32'h100,      32'h1C8,  32'h290,  32'h4000, 32'h4250};
    vec[4] = '{3,   3, 32'h500,      32'h600,  0, 1, 2, 1'b0, 1,  -1, 32'h500,      32'h503,  32'h506,  32'h600,  32'h600};
    vec[5] = '{10,  2, 32'h0,        32'h0,    0, 0, 1, 1'b1, 0,  1,  32'h0,        32'h0,    32'h0,    32'h0,    32'h0};
    vec[6] = '{65,  3, 32'h0,        32'h1000, 1, 0, 1, 1'b0, 2,  -1, 32'h0,        32'h41,   32'h82,   32'h1000, 32'h1040};
    vec[7] = '{64,  3, 32'hFFFFFFC0, 32'h2000, 0, 0, 1, 1'b0, 1,  8,  32'hFFFFFFC0, 32'h0,    32'h40,   32'h2000, 32'h2000};

    // Reset state.
    #23;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dim_err", dim_err, 1'b0);
    check("reset_rd_req", bus.mem_rd_req, 1'b0);
    check("reset_wr_req", bus.mem_wr_req, 1'b0);
    check("reset_go", bus.fpu_go, 1'b0);
    check("reset_state", fsm_state, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("v%0d", i);
      rd_lat_cfg = vec[i].rdl;
      wr_lat_cfg = vec[i].wrl;
      fpu_lat_cfg = vec[i].fpl;
      noise = 1'b0;
      run_job(nm, vec[i].w, vec[i].h, vec[i].sa, vec[i].ra, 2000, lat, nch);
      check({nm, "_dim_err"}, dim_err, vec[i].err);
      check({nm, "_chunks"}, obs_wr.size(), vec[i].chunks);
      check({nm, "_go_count"}, go_count, vec[i].chunks);
      if (vec[i].done_lat > 0) check({nm, "_done_latency"}, lat, vec[i].done_lat);
      if (vec[i].chunks > 0) begin
        check({nm, "_rd0"}, obs_rd[0], vec[i].rd0);
        check({nm, "_rd1"}, obs_rd[1], vec[i].rd1);
        check({nm, "_rd2"}, obs_rd[2], vec[i].rd2);
        check({nm, "_wr0"}, obs_wr[0], vec[i].wr0);
        check({nm, "_wr_last"}, obs_wr[obs_wr.size() - 1], vec[i].wr_last);
      end
      if (vec[i].w == 100 && vec[i].h == 4) begin
        check({nm, "_rd_r0c1_k0"}, obs_rd[3], 32'h40);
        check({nm, "_rd_r0c1_k1"}, obs_rd[4], 32'hA4);
        check({nm, "_rd_r0c1_k2"}, obs_rd[5], 32'h108);
        check({nm, "_wr_r1c0"}, obs_wr[2], 32'h8064);
      end
    end

    // Slow memory, plus a stray start while the second row read waits: sequence must not change.
    rd_lat_cfg = 5; wr_lat_cfg = 5; fpu_lat_cfg = 3; noise = 1'b0;
    fork
      run_job("slow", 100, 4, 32'h0, 32'h8000, 2000, lat, nch);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.mem_rd_req && bus.fpu_load_row == 2'd1) && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("slow_found_rd1", bus.mem_rd_req && bus.fpu_load_row == 2'd1, 1'b1);
        @(posedge clk); #1;
        image_width = 16'd64; image_height = 16'd3;
        start_address = 32'hDEAD0000; result_address = 32'hBEEF0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    check("slow_chunks", obs_wr.size(), 4);
    check("slow_busy_idle", busy, 1'b0);

    // Reset during COMPUTE of the second chunk, then a fresh job must start from r=0, c=0.
    rd_lat_cfg = 0; wr_lat_cfg = 0; fpu_lat_cfg = 6;
    nch = build_expected(100, 4, 32'h0, 32'h8000);
    go_count = 0;
    @(posedge clk); #1;
    image_width = 16'd100; image_height = 16'd4;
    start_address = 32'h0; result_address = 32'h8000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n;
      n = 0;
      while (go_count < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_reached_chunk2", go_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_rd_req", bus.mem_rd_req, 1'b0);
    check("rst_wr_req", bus.mem_wr_req, 1'b0);
    check("rst_wr_addr", bus.mem_wr_addr, 32'h0);
    check("rst_go", bus.fpu_go, 1'b0);
    check("rst_last_chunk", bus.fpu_last_chunk, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", fsm_state, 3'd0);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fpu_lat_cfg = 1;
    run_job("after_rst", 100, 4, 32'h0, 32'h8000, 2000, lat, nch);
    check("after_rst_rd0", obs_rd[0], 32'h0);
    check("after_rst_wr0", obs_wr[0], 32'h8000);
    check("after_rst_chunks", obs_wr.size(), 4);

    // Random jobs with random latencies and stray acks/fpu_done outside their windows.
    rd_lat_cfg = -1; wr_lat_cfg = -1; fpu_lat_cfg = -1; noise = 1'b1;
    for (int j = 0; j < 10; j++) begin
      w = ($urandom_range(5, 0) == 0) ? int'($urandom_range(2, 0)) : int'($urandom_range(200, 3));
      h = ($urandom_range(5, 0) == 0) ? int'($urandom_range(2, 0)) : int'($urandom_range(6, 3));
      budget = 60 * ((w + LB - 1) / LB + 1) * (h + 1) + 40;
      nm = $sformatf("rand%0d", j);
      run_job(nm, w, h, $urandom, $urandom, budget, lat, nch);
      check({nm, "_dim_err"}, dim_err, (w < 3 || h < 3));
      check({nm, "_chunks"}, obs_wr.size(), nch);
    end
    noise = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=still running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
